lsu_mem_master: RTL

- Load/store initiator for the word-addressed data memory.
  - Accepts one RISC-V load/store request at a time from the core.
  - Converts byte addresses to word indices and drives the memory A/WD/WE pins.
  - Returns sign/zero-extended load data.
- Byte/halfword stores use read-modify-write, because the memory only supports full-word writes.
- Misaligned, out-of-range and illegal requests are rejected without touching memory.

---
 rtl/lsu_mem_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store initiator for a word-addressed 32-bit data memory. It takes one
//   RISC-V load/store request at a time and returns a single-cycle response.
//   Byte and halfword stores use read-modify-write because the memory only
//   writes full words. Misaligned, out-of-range and illegal requests get an
//   error response and never touch memory.
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous reset, active low
//   req_valid   request present
//   req_ready   request can be accepted (IDLE only)
//   req_we      0 = load, 1 = store
//   req_funct3  000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    byte address
//   req_wdata   store data (B/H use the low bits)
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   extended load data, 0 for stores and errors
//   rsp_err     request rejected, qualified by rsp_valid
//   mem_A       word index to memory
//   mem_WD      write data to memory
//   mem_WE      memory write enable
//   mem_RD      combinational read data from memory
module lsu_mem_master #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam logic [31:0] MEM_WORDS_32 = 32'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // Rejection check, evaluated on the raw request at accept time.
  function automatic logic req_is_bad(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:         bad = 1'b0;
      3'b001:         bad = a[0];
      3'b010:         bad = (a[1:0] != 2'b00);
      3'b100:         bad = we;
      3'b101:         bad = we | a[0];
      default:        bad = 1'b1;
    endcase
    if ({2'b00, a[31:2]} >= MEM_WORDS_32) bad = 1'b1;
    return bad;
  endfunction

  // Little-endian byte/halfword extraction with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [31:0] sb, sh, res;
    sb = word >> {a, 3'b000};
    sh = word >> {a[1], 4'b0000};
    case (f3)
      3'b000:  res = {{24{sb[7]}}, sb[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'h000000, sb[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Insert the store byte/halfword into the word captured during READ.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [31:0] mask, ins;
    if (f3 == 3'b000) begin
      mask = 32'h0000_00FF << {a, 3'b000};
      ins  = {24'h000000, wd[7:0]} << {a, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {a[1], 4'b0000};
      ins  = {16'h0000, wd[15:0]} << {a[1], 4'b0000};
    end
    return (word & ~mask) | (ins & mask);
  endfunction

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    mem_A     = 32'h0;
    mem_WD    = 32'h0;
    mem_WE    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          data_d  = 32'h0;
          if (req_is_bad(req_we, req_funct3, req_addr)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            // Only full-word stores skip the read half of read-modify-write.
            state_d = (req_we && req_funct3 == 3'b010) ? WRITE : READ;
          end
        end
      end
      READ: begin
        mem_A   = {2'b00, addr_q[31:2]};
        data_d  = mem_RD;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_A   = {2'b00, addr_q[31:2]};
        mem_WE  = 1'b1;
        mem_WD  = (f3_q == 3'b010) ? wdata_q
                                   : store_merge(data_q, wdata_q, f3_q, addr_q[1:0]);
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? 32'h0 : load_extract(data_q, f3_q, addr_q[1:0]);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset drops state to IDLE at once, so a pending WRITE never reaches
  // its closing edge with mem_WE high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule
